// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// The slave modport is the arbiter; master is the surrounding core and memory.
interface mem_arbiter_if #(
  parameter int N = 64
);
  logic         f_req;
  logic [N-1:0] f_adr;
  logic         f_gnt;
  logic         f_rvalid;
  logic [31:0]  f_rdata;

  logic         d_req;
  logic [1:0]   d_we;
  logic         d_readtype;
  logic [N-1:0] d_adr;
  logic [N-1:0] d_wdata;
  logic         d_gnt;
  logic         d_rvalid;
  logic [N-1:0] d_rdata;

  logic         g_req;
  logic [7:0]   g_adr;
  logic         g_gnt;
  logic         g_rvalid;
  logic [31:0]  g_rdata;

  logic [N-1:0] m_adr;
  logic [N-1:0] m_wdata;
  logic [1:0]   m_write;
  logic         m_readtype;
  logic [N-1:0] m_rdata;
  logic         busy;

  modport slave (
    input  f_req, f_adr, d_req, d_we, d_readtype, d_adr, d_wdata,
    input  g_req, g_adr, m_rdata,
    output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
    output g_gnt, g_rvalid, g_rdata,
    output m_adr, m_wdata, m_write, m_readtype, busy
  );

  modport master (
    output f_req, f_adr, d_req, d_we, d_readtype, d_adr, d_wdata,
    output g_req, g_adr, m_rdata,
    input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
    input  g_gnt, g_rvalid, g_rdata,
    input  m_adr, m_wdata, m_write, m_readtype, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fetch, data and debug share one memory,
// fixed priority with starvation promotion, fixed-latency access FSM.
module mem_arbiter #(
  parameter int N      = 64,
  parameter int MEMLAT = 2,
  parameter int STARVE = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  typedef enum logic [1:0] {OWN_D, OWN_F, OWN_G} own_e;

  localparam logic [3:0] LAT = 4'(MEMLAT);
  localparam logic [3:0] SAT = 4'(STARVE);

  state_e       state_q, state_d;
  own_e         own_q, own_d, win;
  logic         any;
  logic         last;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   fage_q, fage_d;
  logic [3:0]   gage_q, gage_d;
  logic [N-1:0] adr_q, adr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic [1:0]   we_q, we_d;
  logic         rt_q, rt_d;
  logic [31:0]  frd_q, frd_d;
  logic [31:0]  grd_q, grd_d;
  logic [N-1:0] drd_q, drd_d;

  // promoted requesters jump ahead of the data > fetch > debug order
  always_comb begin
    any = reset & (bus.f_req | bus.d_req | bus.g_req);
    win = OWN_D;
    if (bus.f_req && fage_q >= SAT)      win = OWN_F;
    else if (bus.g_req && gage_q >= SAT) win = OWN_G;
    else if (bus.d_req)                  win = OWN_D;
    else if (bus.f_req)                  win = OWN_F;
    else if (bus.g_req)                  win = OWN_G;
  end

  assign last = (state_q == ACCESS) && (cnt_q == 4'd1);

  always_comb begin
    state_d        = state_q;
    own_d          = own_q;
    cnt_d          = cnt_q;
    fage_d         = fage_q;
    gage_d         = gage_q;
    adr_d          = adr_q;
    wdata_d        = wdata_q;
    we_d           = we_q;
    rt_d           = rt_q;
    bus.f_gnt      = 1'b0;
    bus.d_gnt      = 1'b0;
    bus.g_gnt      = 1'b0;
    bus.f_rvalid   = 1'b0;
    bus.d_rvalid   = 1'b0;
    bus.g_rvalid   = 1'b0;
    bus.m_adr      = '0;
    bus.m_wdata    = '0;
    bus.m_write    = 2'b00;
    bus.m_readtype = 1'b0;
    bus.busy       = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d = ACCESS;
          own_d   = win;
          cnt_d   = LAT;
          unique case (win)
            OWN_F: begin
              bus.f_gnt = 1'b1;
              adr_d     = bus.f_adr;
              wdata_d   = '0;
              we_d      = 2'b00;
              rt_d      = 1'b0;
            end
            OWN_G: begin
              bus.g_gnt = 1'b1;
              adr_d     = {{(N-8){1'b0}}, bus.g_adr};
              wdata_d   = '0;
              we_d      = 2'b00;
              rt_d      = 1'b0;
            end
            default: begin
              bus.d_gnt = 1'b1;
              adr_d     = bus.d_adr;
              wdata_d   = bus.d_wdata;
              we_d      = bus.d_we;
              rt_d      = bus.d_readtype;
            end
          endcase
          if (win == OWN_F)
            fage_d = '0;
          else if (bus.f_req && fage_q < SAT)
            fage_d = fage_q + 4'd1;
          if (win == OWN_G)
            gage_d = '0;
          else if (bus.g_req && gage_q < SAT)
            gage_d = gage_q + 4'd1;
        end
      end
      ACCESS: begin
        bus.m_adr      = adr_q;
        bus.m_wdata    = wdata_q;
        bus.m_readtype = rt_q;
        cnt_d          = cnt_q - 4'd1;
        if (last) begin
          state_d = DONE;
          if (own_q == OWN_D) bus.m_write = we_q;
        end
      end
      DONE: begin
        state_d      = IDLE;
        bus.f_rvalid = (own_q == OWN_F);
        bus.d_rvalid = (own_q == OWN_D);
        bus.g_rvalid = (own_q == OWN_G);
      end
      default: state_d = IDLE;
    endcase
  end

  // kept apart from the bus drivers: m_rdata returns combinationally from m_adr
  always_comb begin
    frd_d = frd_q;
    grd_d = grd_q;
    drd_d = drd_q;
    if (last) begin
      unique case (own_q)
        OWN_F:   frd_d = bus.m_rdata[31:0];
        OWN_G:   grd_d = bus.m_rdata[31:0];
        default: if (we_q == 2'b00) drd_d = bus.m_rdata;
      endcase
    end
  end

  assign bus.f_rdata = frd_q;
  assign bus.g_rdata = grd_q;
  assign bus.d_rdata = drd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      own_q   <= OWN_D;
      cnt_q   <= '0;
      fage_q  <= '0;
      gage_q  <= '0;
      adr_q   <= '0;
      wdata_q <= '0;
      we_q    <= 2'b00;
      rt_q    <= 1'b0;
      frd_q   <= '0;
      grd_q   <= '0;
      drd_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      fage_q  <= fage_d;
      gage_q  <= gage_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rt_q    <= rt_d;
      frd_q   <= frd_d;
      grd_q   <= grd_d;
      drd_q   <= drd_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mem_arbiter;
  localparam int N      = 64;
  localparam int MEMLAT = 2;
  localparam int STARVE = 4;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   wcnt = 0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.N(N)) bus ();

  mem_arbiter #(.N(N), .MEMLAT(MEMLAT), .STARVE(STARVE)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [63:0] mem [0:255];

  function automatic logic [63:0] mrd(input logic [63:0] a, input logic rt);
    logic [63:0] w;
    w = mem[a[10:3]];
    if (rt) return w;
    return {32'h0, a[2] ? w[63:32] : w[31:0]};
  endfunction

  always_comb bus.m_rdata = mrd(bus.m_adr, bus.m_readtype);

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] <= {32'(i) ^ 32'h5A5A0000, 32'(i) * 32'h01010101};
    mem[0] <= 64'hCAFEF00D_12345678;
    mem[2] <= 64'hA5A5A5A5_20080005;
    mem[8] <= 64'h0;
  end

  always @(posedge clk) begin
    if (reset && bus.m_write != 2'b00) begin
      if (bus.m_write == 2'b11)
        mem[bus.m_adr[10:3]] <= bus.m_wdata;
      else if (bus.m_adr[2])
        mem[bus.m_adr[10:3]][63:32] <= bus.m_wdata[31:0];
      else
        mem[bus.m_adr[10:3]][31:0] <= bus.m_wdata[31:0];
      wcnt <= wcnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
  endtask

  task automatic timeout(input string nm);
    checks++;
    $display("FAIL %s act=no-event exp=event t=%0t", nm, $time);
  endtask

  // reference model: owner, remaining busy cycles, latched request, ages
  int          rem = 0;
  int          own = 0;
  int          fage = 0;
  int          gage = 0;
  logic [63:0] ladr = '0;
  logic [63:0] lwd = '0;
  logic [1:0]  lwe = '0;
  logic        lrt = 1'b0;
  logic [63:0] ef = '0;
  logic [63:0] ed = '0;
  logic [63:0] eg = '0;

  function automatic int pick();
    if (bus.f_req && fage >= STARVE) return 1;
    if (bus.g_req && gage >= STARVE) return 2;
    if (bus.d_req) return 0;
    if (bus.f_req) return 1;
    if (bus.g_req) return 2;
    return -1;
  endfunction

  always @(negedge clk) begin : model
    logic [2:0]  xg;
    logic [2:0]  xv;
    logic [63:0] xa;
    logic [63:0] xw;
    logic [63:0] rd;
    logic [1:0]  xm;
    logic        xr;
    logic        xb;
    int          w;
    xg = '0; xv = '0; xa = '0; xw = '0; xm = '0; xr = 1'b0; w = -1;
    if (!reset) begin
      rem = 0; fage = 0; gage = 0;
      ef = '0; ed = '0; eg = '0;
    end else if (rem == 0) begin
      w = pick();
      if (w >= 0) xg[2'(w)] = 1'b1;
    end else if (rem > 1) begin
      xa = ladr; xw = lwd; xr = lrt;
      if (rem == 2 && own == 0) xm = lwe;
    end else begin
      xv[2'(own)] = 1'b1;
    end
    xb = (rem != 0);
    chk("d_gnt", 64'(bus.d_gnt), 64'(xg[0]));
    chk("f_gnt", 64'(bus.f_gnt), 64'(xg[1]));
    chk("g_gnt", 64'(bus.g_gnt), 64'(xg[2]));
    chk("d_rvalid", 64'(bus.d_rvalid), 64'(xv[0]));
    chk("f_rvalid", 64'(bus.f_rvalid), 64'(xv[1]));
    chk("g_rvalid", 64'(bus.g_rvalid), 64'(xv[2]));
    chk("busy", 64'(bus.busy), 64'(xb));
    chk("m_adr", bus.m_adr, xa);
    chk("m_wdata", bus.m_wdata, xw);
    chk("m_write", 64'(bus.m_write), 64'(xm));
    chk("m_readtype", 64'(bus.m_readtype), 64'(xr));
    chk("f_rdata", 64'(bus.f_rdata), ef);
    chk("d_rdata", bus.d_rdata, ed);
    chk("g_rdata", 64'(bus.g_rdata), eg);
    if (reset) begin
      if (rem == 0) begin
        if (w >= 0) begin
          own = w;
          rem = MEMLAT + 1;
          if (w == 0) begin
            ladr = bus.d_adr; lwd = bus.d_wdata; lwe = bus.d_we; lrt = bus.d_readtype;
          end else if (w == 1) begin
            ladr = bus.f_adr; lwd = '0; lwe = '0; lrt = 1'b0;
          end else begin
            ladr = {56'h0, bus.g_adr}; lwd = '0; lwe = '0; lrt = 1'b0;
          end
          if (w == 1) fage = 0;
          else if (bus.f_req && fage < STARVE) fage++;
          if (w == 2) gage = 0;
          else if (bus.g_req && gage < STARVE) gage++;
        end
      end else begin
        if (rem == 2) begin
          rd = mrd(ladr, lrt);
          if (own == 1) ef = {32'h0, rd[31:0]};
          else if (own == 2) eg = {32'h0, rd[31:0]};
          else if (lwe == 2'b00) ed = rd;
        end
        rem--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic gnt_of(input int who);
    return who == 0 ? bus.d_gnt : who == 1 ? bus.f_gnt : bus.g_gnt;
  endfunction

  function automatic logic rv_of(input int who);
    return who == 0 ? bus.d_rvalid : who == 1 ? bus.f_rvalid : bus.g_rvalid;
  endfunction

  task automatic wait_gnt(input int who, output int c);
    c = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (gnt_of(who)) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) timeout("wait_gnt");
  endtask

  task automatic wait_rv(input int who, output int c);
    c = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rv_of(who)) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) timeout("wait_rvalid");
  endtask

  initial begin
    int t, r, w0, cd, cf, cg, n, a1, a2, nb;
    logic [63:0] orig;
    reset = 1'b0;
    bus.f_req = 1'b0; bus.f_adr = '0;
    bus.d_req = 1'b0; bus.d_we = 2'b00; bus.d_readtype = 1'b0;
    bus.d_adr = '0; bus.d_wdata = '0;
    bus.g_req = 1'b0; bus.g_adr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_d_rdata", bus.d_rdata, 64'd0);
    reset = 1'b1;
    tick();

    // single fetch
    bus.f_req = 1'b1; bus.f_adr = 64'h10;
    wait_gnt(1, t);
    tick();
    bus.f_req = 1'b0;
    wait_rv(1, r);
    chk("fetch_latency", 64'(r - t), 64'd3);
    chk("fetch_data", 64'(bus.f_rdata), 64'h20080005);
    tick();

    // doubleword write then read back
    w0 = wcnt;
    bus.d_req = 1'b1; bus.d_we = 2'b11; bus.d_readtype = 1'b1;
    bus.d_adr = 64'h40; bus.d_wdata = 64'h1122334455667788;
    wait_gnt(0, t);
    tick();
    bus.d_req = 1'b0;
    wait_rv(0, r);
    chk("write_cycles", 64'(wcnt - w0), 64'd1);
    chk("write_rdata_kept", bus.d_rdata, 64'd0);
    tick();
    bus.d_req = 1'b1; bus.d_we = 2'b00;
    wait_gnt(0, t);
    tick();
    bus.d_req = 1'b0;
    wait_rv(0, r);
    chk("read_back", bus.d_rdata, 64'h1122334455667788);
    tick();

    // three-way contention
    bus.g_adr = 8'h03;
    bus.d_req = 1'b1; bus.f_req = 1'b1; bus.g_req = 1'b1;
    t = cyc; cd = -1; cf = -1; cg = -1;
    for (int i = 0; i < 40 && (cd < 0 || cf < 0 || cg < 0); i++) begin
      @(negedge clk);
      if (bus.d_gnt) cd = cyc;
      if (bus.f_gnt) cf = cyc;
      if (bus.g_gnt) cg = cyc;
      tick();
      if (cd >= 0) bus.d_req = 1'b0;
      if (cf >= 0) bus.f_req = 1'b0;
      if (cg >= 0) bus.g_req = 1'b0;
    end
    bus.d_req = 1'b0; bus.f_req = 1'b0; bus.g_req = 1'b0;
    chk("contend_data_t", 64'(cd - t), 64'd0);
    chk("contend_fetch_t", 64'(cf - t), 64'd4);
    chk("contend_dbg_t", 64'(cg - t), 64'd8);
    wait_rv(2, r);
    tick();

    // starvation: data held, fetch held
    bus.d_req = 1'b1; bus.d_we = 2'b00; bus.f_req = 1'b1;
    n = 0; a1 = -1; a2 = -1;
    for (int i = 0; i < 200 && a2 < 0; i++) begin
      @(negedge clk);
      if (bus.d_gnt || bus.f_gnt || bus.g_gnt) n++;
      if (bus.f_gnt) begin
        if (a1 < 0) a1 = n;
        else a2 = n;
      end
    end
    tick();
    bus.d_req = 1'b0; bus.f_req = 1'b0;
    chk("starve_first", 64'(a1), 64'd5);
    chk("starve_again", 64'(a2 - a1), 64'd5);
    wait_rv(1, r);
    tick();

    // debug read
    bus.g_req = 1'b1; bus.g_adr = 8'h03;
    wait_gnt(2, t);
    tick();
    bus.g_req = 1'b0;
    chk("dbg_m_adr", bus.m_adr, 64'h3);
    chk("dbg_m_write", 64'(bus.m_write), 64'd0);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy) nb++;
      else break;
    end
    chk("dbg_busy_len", 64'(nb), 64'(MEMLAT + 1));
    chk("dbg_rdata", 64'(bus.g_rdata), 64'h12345678);
    tick();

    // reset while the write is on its last access cycle
    orig = mem[16];
    bus.d_req = 1'b1; bus.d_we = 2'b11; bus.d_readtype = 1'b1;
    bus.d_adr = 64'h80; bus.d_wdata = 64'hDEADBEEF_00C0FFEE;
    wait_gnt(0, t);
    tick();
    bus.d_req = 1'b0;
    tick();
    chk("pre_rst_m_write", 64'(bus.m_write), 64'd3);
    w0 = wcnt;
    reset = 1'b0;
    #1;
    chk("rst_m_write", 64'(bus.m_write), 64'd0);
    chk("rst_busy2", 64'(bus.busy), 64'd0);
    chk("rst_m_adr", bus.m_adr, 64'd0);
    chk("rst_d_rdata2", bus.d_rdata, 64'd0);
    chk("rst_f_rdata", 64'(bus.f_rdata), 64'd0);
    chk("rst_g_rdata", 64'(bus.g_rdata), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_no_commit", mem[16], orig);
    chk("rst_no_wcnt", 64'(wcnt - w0), 64'd0);
    chk("rst_no_rvalid", 64'(bus.d_rvalid), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
